// File: rtl/arithmetic_logic_pipeline.sv
// Purpose : ALU with registered result flags and an iterative shift-add multiplier.
// Latency : ops 0-6 registered at the acceptance edge; MUL completes WIDTH edges after acceptance.
// Backpr. : in_ready low while a multiply runs; in_valid is ignored then, nothing is queued.
//
// Ports: clk/reset (sync, active-high); A, B, Imm operands; ALUsrc picks Imm (1) or B (0);
//        ALUop operation code; in_valid/in_ready request handshake;
//        ALUout, AltB, zero, ovf result registers; out_valid one-cycle completion pulse.
module arithmetic_logic_pipeline #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Imm,
    input  logic             ALUsrc,
    input  logic [2:0]       ALUop,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ALUout,
    output logic             AltB,
    output logic             zero,
    output logic             ovf,
    output logic             out_valid
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 altb_pend_q, altb_pend_d;   // A<Y captured at MUL acceptance
    logic [WIDTH-1:0]     alu_out_q, alu_out_d;
    logic                 altb_q, altb_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic [WIDTH-1:0]     y, sum, diff, res;
    logic                 lt, res_ovf;
    logic [2*WIDTH-1:0]   acc_step;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; cnt_q == 1 marks the final multiply iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && ALUop == OP_MUL) state_d = MUL_RUN;
            MUL_RUN: if (cnt_q == CW'(1))           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    assign accept   = in_valid && in_ready;
    assign y        = ALUsrc ? Imm : B;
    assign sum      = A + y;
    assign diff     = A - y;
    assign lt       = $signed(A) < $signed(y);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle result and signed-overflow flag
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        case (ALUop)
            OP_AND: res = A & y;
            OP_OR:  res = A | y;
            OP_ADD: begin
                res     = sum;
                res_ovf = (A[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res     = diff;
                res_ovf = (A[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, lt};
            OP_SLL: res = A << y[SHW-1:0];
            OP_SRL: res = A >> y[SHW-1:0];
            default: res = '0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        altb_pend_d = altb_pend_q;
        alu_out_d   = alu_out_q;
        altb_d      = altb_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                if (ALUop == OP_MUL) begin
                    mcand_d     = {{WIDTH{1'b0}}, A};
                    mplier_d    = y;
                    acc_d       = '0;
                    cnt_d       = CW'(WIDTH);
                    altb_pend_d = lt;
                end else begin
                    alu_out_d   = res;
                    zero_d      = (res == '0);
                    ovf_d       = res_ovf;
                    altb_d      = lt;
                    out_valid_d = 1'b1;
                end
            end
        end else begin
            // One multiplier bit per edge, LSB first
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                alu_out_d   = acc_step[WIDTH-1:0];
                zero_d      = (acc_step[WIDTH-1:0] == '0);
                ovf_d       = |acc_step[2*WIDTH-1:WIDTH];
                altb_d      = altb_pend_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            altb_pend_q <= 1'b0;
            alu_out_q   <= '0;
            altb_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            altb_pend_q <= altb_pend_d;
            alu_out_q   <= alu_out_d;
            altb_q      <= altb_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ALUout    = alu_out_q;
    assign AltB      = altb_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_arithmetic_logic_pipeline.sv
module tb_arithmetic_logic_pipeline;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] A, B, Imm;
    logic         ALUsrc;
    logic [2:0]   ALUop;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ALUout;
    logic         AltB, zero, ovf, out_valid;

    int total = 0;
    int bad   = 0;

    arithmetic_logic_pipeline #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Imm(Imm), .ALUsrc(ALUsrc),
        .ALUop(ALUop), .in_valid(in_valid), .in_ready(in_ready), .ALUout(ALUout),
        .AltB(AltB), .zero(zero), .ovf(ovf), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operation's definition
    task automatic ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] y,
                             output logic [W-1:0] r, output logic o, output logic l);
        longint sa, sy, s, ua, uy, p;
        int     sh;
        sa = longint'($signed(a));
        sy = longint'($signed(y));
        ua = longint'(a);
        uy = longint'(y);
        sh = int'(y) % W;
        o  = 1'b0;
        l  = (sa < sy);
        case (op)
            3'd0: r = a & y;
            3'd1: r = a | y;
            3'd2: begin s = sa + sy; r = W'(ua + uy); o = (s > 32767) || (s < -32768); end
            3'd3: begin s = sa - sy; r = W'(ua - uy); o = (s > 32767) || (s < -32768); end
            3'd4: r = l ? W'(1) : W'(0);
            3'd5: r = W'((ua * (64'd1 << sh)) % 65536);
            3'd6: r = W'(ua / (64'd1 << sh));
            default: begin p = ua * uy; r = W'(p % 65536); o = (p / 65536) != 0; end
        endcase
    endtask

    // Issue one request, scramble inputs afterwards, wait for completion and check.
    // poke keeps in_valid high with junk while the unit is busy.
    task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] imm, input logic src,
                         input logic poke);
        logic [W-1:0] r, y;
        logic         o, l;
        int           cyc, exp_cyc;
        y = src ? imm : b;
        ref_model(op, a, y, r, o, l);
        exp_cyc = (op == 3'd7) ? W : 0;
        @(negedge clk);
        A = a; B = b; Imm = imm; ALUsrc = src; ALUop = op; in_valid = 1'b1;
        @(negedge clk);
        in_valid = poke; A = W'($urandom); B = W'($urandom); Imm = W'($urandom);
        ALUsrc = 1'($urandom); ALUop = poke ? 3'd2 : 3'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s busy_ready: got %b want 0 at cycle %0d", name, in_ready, cyc);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (cyc !== exp_cyc) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_cyc);
        end
        total++;
        if ({ALUout, zero, ovf, AltB, out_valid, in_ready} !== {r, (r == '0), o, l, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL %s result: got out=%h z=%b o=%b lt=%b v=%b rdy=%b want out=%h z=%b o=%b lt=%b v=1 rdy=1",
                     name, ALUout, zero, ovf, AltB, out_valid, in_ready, r, (r == '0), o, l);
        end
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, ALUout} !== {1'b0, 1'b1, r}) begin
            bad++;
            $display("FAIL %s after: got v=%b rdy=%b out=%h want v=0 rdy=1 out=%h",
                     name, out_valid, in_ready, ALUout, r);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; Imm = '0; ALUsrc = 1'b0; ALUop = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total++;
        if ({ALUout, AltB, zero, ovf, out_valid, in_ready} !== {16'h0000, 5'b00001}) begin
            bad++;
            $display("FAIL reset: got out=%h lt=%b z=%b o=%b v=%b rdy=%b want 0000 0 0 0 0 1",
                     ALUout, AltB, zero, ovf, out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        do_op("and_imm", 3'd0, 16'hFFF6, 16'h1234, 16'h000A, 1'b1, 1'b0);
        do_op("sub_ovf", 3'd3, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0);
        do_op("sll", 3'd5, 16'h0003, 16'hFFF4, 16'h0000, 1'b0, 1'b0);
        do_op("srl", 3'd6, 16'h8000, 16'h0000, 16'h001F, 1'b1, 1'b0);
        do_op("slt", 3'd4, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        A = 16'hFFFF; B = 16'h0001; Imm = 16'h0000; ALUsrc = 1'b0; ALUop = 3'd2; in_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({ALUout, zero, ovf, out_valid, in_ready} !== {16'h0000, 4'b1011}) begin
            bad++;
            $display("FAIL b2b_add: got out=%h z=%b o=%b v=%b rdy=%b want 0000 1 0 1 1",
                     ALUout, zero, ovf, out_valid, in_ready);
        end
        A = 16'h00F0; Imm = 16'h000F; ALUsrc = 1'b1; ALUop = 3'd1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({ALUout, zero, ovf, out_valid} !== {16'h00FF, 3'b001}) begin
            bad++;
            $display("FAIL b2b_or: got out=%h z=%b o=%b v=%b want 00ff 0 0 1", ALUout, zero, ovf, out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_mul();
        do_op("mul_a", 3'd7, 16'h0123, 16'h0010, 16'hFFFF, 1'b0, 1'b1);
        do_op("mul_b", 3'd7, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0);
        do_op("mul_imm", 3'd7, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
    endtask

    task automatic test_mul_reset();
        int pulses;
        @(negedge clk);
        A = 16'h0123; B = 16'h0045; ALUsrc = 1'b0; ALUop = 3'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({ALUout, AltB, zero, ovf, out_valid, in_ready} !== {16'h0000, 5'b00001}) begin
            bad++;
            $display("FAIL mul_abort: got out=%h lt=%b z=%b o=%b v=%b rdy=%b want 0000 0 0 0 0 1",
                     ALUout, AltB, zero, ovf, out_valid, in_ready);
        end
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL mul_abort_pulse: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_reset_priority();
        do_op("pre_rst", 3'd2, 16'h1000, 16'h0234, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        A = 16'h0005; Imm = 16'h0003; ALUsrc = 1'b1; ALUop = 3'd1; in_valid = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        total++;
        if ({ALUout, zero, out_valid, in_ready} !== {16'h0000, 3'b001}) begin
            bad++;
            $display("FAIL rst_prio: got out=%h z=%b v=%b rdy=%b want 0000 0 0 1", ALUout, zero, out_valid, in_ready);
        end
        @(negedge clk);
        total++;
        if ({ALUout, out_valid} !== {16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL rst_prio_drop: got out=%h v=%b want 0000 0", ALUout, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op("random", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), W'($urandom),
                  1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mul();
        test_mul_reset();
        test_reset_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
